// File: rtl/ahbl_qspi_xip_cache_if.sv
// AHB-Lite slave-side bus bundle for the quad-I/O XIP cache.
// Master drives address/control, slave returns ready and read data.
interface ahbl_qspi_xip_cache_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface

// File: rtl/ahbl_qspi_xip_cache.sv
// Read-only AHB-Lite XIP slave: direct-mapped line cache filled via 0xEB quad read.
// Define AHBL_QSPI_XIP_STATS_EN to add hit/miss counters and stats_clr.
module ahbl_qspi_xip_cache #(
    parameter int NUM_LINES    = 16,
    parameter int LINE_BYTES   = 16,
    parameter int DUMMY_CYCLES = 4,
    parameter int ADDR_W       = 24
) (
    input  logic       HCLK,
    input  logic       HRESET,
    ahbl_qspi_xip_cache_if.slave ahb,
    input  logic       inv,
    output logic       csn,
    output logic       sck,
    output logic [3:0] doe,
    output logic [3:0] dout,
    input  logic [3:0] di
`ifdef AHBL_QSPI_XIP_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int OFF  = $clog2(LINE_BYTES);
    localparam int IW   = $clog2(NUM_LINES);
    localparam int TW   = ADDR_W - OFF - IW;
    localparam int NB   = 2 * LINE_BYTES;
    localparam int MB   = (DUMMY_CYCLES > NB) ? DUMMY_CYCLES : NB;
    localparam int CW   = $clog2(MB);
    localparam logic [7:0] CMD_B = 8'hEB;

    typedef enum logic [2:0] {
        IDLE, CMD, ADR, MODE, DUMMY, DATA, DONE, RESP
    } st_t;

    st_t st, succ;
    logic [CW-1:0] cnt, last;
    logic ph, inv_seen;

    logic [7:0]     mem  [NUM_LINES][LINE_BYTES];
    logic [TW-1:0]  tags [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    logic [IW-1:0]  idx, f_idx;
    logic [TW-1:0]  tag, f_tag;
    logic [OFF-1:0] boff, f_boff;
    logic [23:0]    fbase;
    logic acc, rd, hit, unused;

    assign idx   = ahb.HADDR[OFF+IW-1:OFF];
    assign tag   = ahb.HADDR[ADDR_W-1:OFF+IW];
    assign boff  = ahb.HADDR[OFF-1:0] & ~OFF'(3);
    assign fbase = 24'({f_tag, f_idx, {OFF{1'b0}}});
    assign acc   = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY
                 & ((st == IDLE) | (st == RESP));
    assign rd    = acc & ~ahb.HWRITE;
    assign hit   = valid[idx] & (tags[idx] == tag);
    assign unused = ^{ahb.HSIZE, ahb.HADDR};

    function automatic logic [31:0] word(input logic [IW-1:0] i,
                                         input logic [OFF-1:0] b);
        word = {mem[i][b + OFF'(3)], mem[i][b + OFF'(2)],
                mem[i][b + OFF'(1)], mem[i][b]};
    endfunction

    // {doe, dout} for the bit/nibble about to be shifted out
    function automatic logic [7:0] pad(input st_t s, input logic [CW-1:0] c,
                                       input logic [23:0] a);
        logic [23:0] sh;
        sh  = a << {c[2:0], 2'b00};
        pad = 8'h00;
        case (s)
            CMD:     pad = {4'hF, 3'b000, CMD_B[~c[2:0]]};
            ADR:     pad = {4'hF, sh[23:20]};
            MODE:    pad = 8'hF0;
            default: pad = 8'h00;
        endcase
    endfunction

    always_comb begin
        last = '0;
        succ = IDLE;
        case (st)
            CMD:   begin last = CW'(7); succ = ADR; end
            ADR:   begin last = CW'(5); succ = MODE; end
            MODE:  begin
                last = CW'(1);
                succ = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
            end
            DUMMY: begin last = CW'(DUMMY_CYCLES - 1); succ = DATA; end
            DATA:  begin last = CW'(NB - 1); succ = DONE; end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && rd && !hit)
            tags[idx] <= tag;
        // di is captured on the edge that raises sck
        if (st == DATA && !ph) begin
            if (!cnt[0]) mem[f_idx][cnt[OFF:1]][7:4] <= di;
            else         mem[f_idx][cnt[OFF:1]][3:0] <= di;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            st            <= IDLE;
            cnt           <= '0;
            ph            <= 1'b0;
            csn           <= 1'b1;
            sck           <= 1'b0;
            doe           <= 4'h0;
            dout          <= 4'h0;
            ahb.HREADYOUT <= 1'b1;
            ahb.HRDATA    <= '0;
            valid         <= '0;
            inv_seen      <= 1'b0;
            f_idx         <= '0;
            f_tag         <= '0;
            f_boff        <= '0;
        end else begin
            if (inv) valid <= '0;
            case (st)
                IDLE, RESP: begin
                    st <= IDLE;
                    if (rd && hit) begin
                        ahb.HRDATA <= word(idx, boff);
                    end else if (rd) begin
                        valid[idx]    <= 1'b0;
                        f_idx         <= idx;
                        f_tag         <= tag;
                        f_boff        <= boff;
                        inv_seen      <= 1'b0;
                        ahb.HREADYOUT <= 1'b0;
                        st            <= CMD;
                        cnt           <= '0;
                        ph            <= 1'b0;
                        csn           <= 1'b0;
                        {doe, dout}   <= pad(CMD, '0, '0);
                    end
                end
                DONE: begin
                    // an invalidate seen at any point of the fill wins
                    if (!inv && !inv_seen) valid[f_idx] <= 1'b1;
                    ahb.HRDATA    <= word(f_idx, f_boff);
                    ahb.HREADYOUT <= 1'b1;
                    st            <= RESP;
                end
                default: begin
                    if (inv) inv_seen <= 1'b1;
                    ph  <= ~ph;
                    sck <= ~ph;
                    if (ph) begin
                        if (cnt == last) begin
                            st          <= succ;
                            cnt         <= '0;
                            csn         <= (succ == DONE);
                            {doe, dout} <= pad(succ, '0, fbase);
                        end else begin
                            cnt         <= cnt + CW'(1);
                            {doe, dout} <= pad(st, cnt + CW'(1), fbase);
                        end
                    end
                end
            endcase
        end
    end

`ifdef AHBL_QSPI_XIP_STATS_EN
    always_ff @(posedge HCLK) begin
        if (HRESET || stats_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rd) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ahbl_qspi_xip_cache.sv
// Directed bench for ahbl_qspi_xip_cache with a behavioural 0xEB quad flash.
// Flash contents: byte[i] = i & 0xFF.
module tb_ahbl_qspi_xip_cache;
    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       inv = 1'b0;
    logic       csn, sck;
    logic [3:0] doe, dout;
    logic [3:0] di = 4'h0;
`ifdef AHBL_QSPI_XIP_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int total = 0;
    int bad = 0;

    ahbl_qspi_xip_cache_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    ahbl_qspi_xip_cache dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .ahb    (bus.slave),
        .inv    (inv),
        .csn    (csn),
        .sck    (sck),
        .doe    (doe),
        .dout   (dout),
        .di     (di)
`ifdef AHBL_QSPI_XIP_STATS_EN
        ,
        .stats_clr (stats_clr),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 HCLK = ~HCLK;

    // flash model: mode 0, samples on sck rise, drives on sck fall
    int n = 0;
    logic [7:0]  cmd = 8'h00;
    logic [23:0] fa = 24'h0;

    always @(negedge csn) n = 0;

    always @(posedge sck) begin
        if (!csn) begin
            if (n < 8)       cmd = {cmd[6:0], dout[0]};
            else if (n < 14) fa = {fa[19:0], dout};
            n++;
        end
    end

    always @(negedge sck) begin
        int k;
        logic [7:0] b;
        if (!csn && n >= 20) begin
            k  = n - 20;
            b  = 8'(fa + 24'(k / 2));
            di = k[0] ? b[3:0] : b[7:4];
        end
    end

    task automatic chk(input string t, input logic [31:0] o,
                       input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", t, o, e);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e,
                      input int ew, input int inv_at, input string t);
        int c;
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = a;
        @(posedge HCLK); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        c = 1;
        while (bus.HREADYOUT !== 1'b1 && c < 400) begin
            inv = (c == inv_at);
            c++;
            @(posedge HCLK); #1;
        end
        inv = 1'b0;
        chk({t, "_wait"}, 32'(c - 1), 32'(ew));
        chk({t, "_data"}, bus.HRDATA, e);
    endtask

    initial begin
        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hready", {31'b0, bus.HREADYOUT}, 32'd1);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_csn", {31'b0, csn}, 32'd1);
        chk("rst_sck", {31'b0, sck}, 32'd0);
        chk("rst_doe", {28'b0, doe}, 32'h0);
        chk("rst_do", {28'b0, dout}, 32'h0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        rd(32'h000, 32'h03020100, 105, -1, "miss0");
        chk("cmd", {24'b0, cmd}, 32'hEB);
        chk("addr0", {8'b0, fa}, 32'h0);
        rd(32'h004, 32'h07060504, 0, -1, "hit4");
        rd(32'h00C, 32'h0F0E0D0C, 0, -1, "hitC");
        rd(32'h100, 32'h03020100, 105, -1, "evict100");
        chk("addr100", {8'b0, fa}, 32'h100);
        rd(32'h000, 32'h03020100, 105, -1, "remiss0");

`ifdef AHBL_QSPI_XIP_STATS_EN
        chk("hit_cnt", hit_cnt, 32'd2);
        chk("miss_cnt", miss_cnt, 32'd3);
        stats_clr = 1'b1;
        @(posedge HCLK); #1;
        stats_clr = 1'b0;
        chk("hit_clr", hit_cnt, 32'd0);
        chk("miss_clr", miss_cnt, 32'd0);
`endif

        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'h000;
        @(posedge HCLK); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        chk("wr_ready", {31'b0, bus.HREADYOUT}, 32'd1);
        rd(32'h008, 32'h0B0A0908, 0, -1, "hit8");

        inv = 1'b1;
        @(posedge HCLK); #1;
        inv = 1'b0;
        rd(32'h004, 32'h07060504, 105, -1, "inv4");

        rd(32'h010, 32'h13121110, 105, 30, "invmid");
        rd(32'h014, 32'h17161514, 105, -1, "aftmid");
        rd(32'h020, 32'h23222120, 105, 105, "invdone");
        rd(32'h024, 32'h27262524, 105, -1, "aftdone");
        rd(32'h028, 32'h2B2A2928, 0, -1, "hit28");

        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = 32'h000;
        @(posedge HCLK); #1;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        chk("f_csn", {31'b0, csn}, 32'd0);
        chk("f_doe_cmd", {28'b0, doe}, 32'hF);
        repeat (39) @(posedge HCLK);
        #1;
        chk("f_doe_dummy", {28'b0, doe}, 32'h0);
        chk("f_busy", {31'b0, bus.HREADYOUT}, 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        chk("ab_csn", {31'b0, csn}, 32'd1);
        chk("ab_sck", {31'b0, sck}, 32'd0);
        chk("ab_doe", {28'b0, doe}, 32'h0);
        chk("ab_ready", {31'b0, bus.HREADYOUT}, 32'd1);
        chk("ab_data", bus.HRDATA, 32'h0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        rd(32'h000, 32'h03020100, 105, -1, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
